heap_writer: RTL and testbench

Allocates tagged Lisp objects in the heap and writes them into memory one word per cycle, producing the same layout that the evaluator's fetch path reads back: tag word at `addr`, payload at `addr+1` and beyond. Sits beside the evaluator core. It drives the memory controller's `addr`, `write_enable` and `write_data` port while the core is not reading. It returns the address of each new object so the core can place it in `expr` or `val`.

---
 rtl/heap_writer_if.sv | 34 +++
 rtl/heap_writer.sv | 132 +++++++++++++
 tb/tb_heap_writer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/heap_writer_if.sv
// Request, status and memory-write signals of the heap writer, grouped so the
// requester and the memory side can be bound as one bundle.
interface heap_writer_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   // Handshake: a request transfers on a rising clk edge where req_valid and
   // req_ready are both high; the requester keeps req_* stable until then.
   logic                  heap_clear;
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_kind;
   logic [DATA_WIDTH-1:0] req_a;
   logic [DATA_WIDTH-1:0] req_b;
   logic                  done;
   logic [ADDR_WIDTH-1:0] done_addr;
   logic                  alloc_error;
   logic [ADDR_WIDTH-1:0] free_ptr;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_write_enable;
   logic [DATA_WIDTH-1:0] mem_write_data;

   modport master (
      output heap_clear, req_valid, req_kind, req_a, req_b,
      input  req_ready, done, done_addr, alloc_error, free_ptr,
             mem_addr, mem_write_enable, mem_write_data
   );

   modport slave (
      input  heap_clear, req_valid, req_kind, req_a, req_b,
      output req_ready, done, done_addr, alloc_error, free_ptr,
             mem_addr, mem_write_enable, mem_write_data
   );
endinterface

// File: rtl/heap_writer.sv
// Bump allocator for tagged Lisp objects: writes tag word then payload words,
// one per cycle, and reports the object's base address.
module heap_writer #(
   parameter int                    ADDR_WIDTH  = 16,
   parameter int                    DATA_WIDTH  = 16,
   parameter logic [ADDR_WIDTH-1:0] HEAP_BASE   = 'h0100,
   parameter logic [ADDR_WIDTH-1:0] HEAP_LIMIT  = 'h01FF,
   parameter int unsigned           TYPE_NUMBER = 1,
   parameter int unsigned           TYPE_CONS   = 2
) (
   input  logic           clk,
   input  logic           rst,
   heap_writer_if.slave   bus,
   output logic [2:0]     dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WR_TAG = 3'd1,
      S_WR_W1  = 3'd2,
      S_WR_W2  = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic                  kind_q, kind_d;
   logic [DATA_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [ADDR_WIDTH-1:0] free_ptr_q, free_ptr_d;
   logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;

   logic                  handshake;
   logic [ADDR_WIDTH:0]   end_addr;

   // Last word of the candidate object, one bit wider so a wrap shows as overflow.
   assign end_addr  = {1'b0, free_ptr_q} +
                      (bus.req_kind ? (ADDR_WIDTH+1)'(2) : (ADDR_WIDTH+1)'(1));
   assign handshake = bus.req_valid && bus.req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         kind_q      <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         free_ptr_q  <= HEAP_BASE;
         last_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         kind_q      <= kind_d;
         a_q         <= a_d;
         b_q         <= b_d;
         free_ptr_q  <= free_ptr_d;
         last_addr_q <= last_addr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      kind_d      = kind_q;
      a_d         = a_q;
      b_d         = b_q;
      free_ptr_d  = free_ptr_q;
      last_addr_d = last_addr_q;
      case (state_q)
         S_IDLE: begin
            if (bus.heap_clear) begin
               free_ptr_d = HEAP_BASE;
            end else if (handshake) begin
               kind_d  = bus.req_kind;
               a_d     = bus.req_a;
               b_d     = bus.req_b;
               base_d  = free_ptr_q;
               state_d = (end_addr > {1'b0, HEAP_LIMIT}) ? S_ERROR : S_WR_TAG;
            end
         end
         S_WR_TAG: state_d = S_WR_W1;
         S_WR_W1:  state_d = kind_q ? S_WR_W2 : S_DONE;
         S_WR_W2:  state_d = S_DONE;
         S_DONE: begin
            free_ptr_d  = base_q + (kind_q ? ADDR_WIDTH'(3) : ADDR_WIDTH'(2));
            last_addr_d = base_q;
            state_d     = S_IDLE;
         end
         S_ERROR: begin
            if (bus.heap_clear) begin
               free_ptr_d = HEAP_BASE;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_ERROR;
      endcase
   end

   always_comb begin
      bus.mem_write_enable = 1'b0;
      bus.mem_addr         = '0;
      bus.mem_write_data   = '0;
      bus.done             = 1'b0;
      bus.alloc_error      = 1'b0;
      case (state_q)
         S_WR_TAG: begin
            bus.mem_write_enable = 1'b1;
            bus.mem_addr         = base_q;
            bus.mem_write_data   = kind_q ? DATA_WIDTH'(TYPE_CONS) : DATA_WIDTH'(TYPE_NUMBER);
         end
         S_WR_W1: begin
            bus.mem_write_enable = 1'b1;
            bus.mem_addr         = base_q + ADDR_WIDTH'(1);
            bus.mem_write_data   = a_q;
         end
         S_WR_W2: begin
            bus.mem_write_enable = 1'b1;
            bus.mem_addr         = base_q + ADDR_WIDTH'(2);
            bus.mem_write_data   = b_q;
         end
         S_DONE:  bus.done        = 1'b1;
         S_ERROR: bus.alloc_error = 1'b1;
         default: ;
      endcase
      bus.done_addr = (state_q == S_DONE) ? base_q : last_addr_q;
      bus.req_ready = (state_q == S_IDLE) && !rst && !bus.heap_clear;
      bus.free_ptr  = free_ptr_q;
      dbg_state_o   = state_q;
   end

endmodule

// File: tb/tb_heap_writer.sv
// Directed bench for heap_writer: an object-level heap model predicts every
// write and done pulse, plus literal expectations from the test plan.
module tb_heap_writer;
   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int BASE  = 'h0100;
   localparam int LIMIT = 'h01FF;
   localparam int TN    = 1;
   localparam int TC    = 2;

   logic       clk;
   logic       rst;
   logic [2:0] dbg_state;

   heap_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   heap_writer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .HEAP_BASE(AW'(BASE)), .HEAP_LIMIT(AW'(LIMIT)),
      .TYPE_NUMBER(TN), .TYPE_CONS(TC)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Object-level model: expected writes and done pulses with their cycle.
   logic [AW-1:0] exp_addr_q[$];
   logic [DW-1:0] exp_data_q[$];
   int            exp_wcyc_q[$];
   logic [AW-1:0] exp_done_q[$];
   int            exp_dcyc_q[$];
   logic [AW-1:0] done_log[$];
   int            hs_cyc_q[$];
   logic [DW-1:0] mem_model [0:1023];
   int            m_fp  = BASE;
   logic          m_err = 1'b0;
   int            cyc   = 0;
   int            hs_count = 0;
   int            sz;
   int            ec;
   logic [AW-1:0] ea;
   logic [DW-1:0] ed;

   task automatic flush_model();
      exp_addr_q.delete(); exp_data_q.delete(); exp_wcyc_q.delete();
      exp_done_q.delete(); exp_dcyc_q.delete();
      m_fp  = BASE;
      m_err = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         cyc++;
         if (bus.mem_write_enable) begin
            mem_model[bus.mem_addr[9:0]] = bus.mem_write_data;
            if (exp_addr_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               ea = exp_addr_q.pop_front();
               ed = exp_data_q.pop_front();
               ec = exp_wcyc_q.pop_front();
               check("write_addr", bus.mem_addr, ea);
               check("write_data", bus.mem_write_data, ed);
               check("write_cycle", cyc, ec);
            end
         end
         if (bus.done) begin
            done_log.push_back(bus.done_addr);
            if (exp_done_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               ea = exp_done_q.pop_front();
               ec = exp_dcyc_q.pop_front();
               check("done_addr", bus.done_addr, ea);
               check("done_cycle", cyc, ec);
            end
         end
         check("alloc_error", bus.alloc_error, m_err);
         check("ready_outside_idle",
               bus.req_ready & (bus.mem_write_enable | bus.done | bus.alloc_error), 0);
         if (bus.heap_clear) begin
            m_fp  = BASE;
            m_err = 1'b0;
         end else if (bus.req_valid && bus.req_ready) begin
            hs_count++;
            hs_cyc_q.push_back(cyc);
            sz = bus.req_kind ? 3 : 2;
            if (m_fp + sz - 1 > LIMIT) begin
               m_err = 1'b1;
            end else begin
               exp_addr_q.push_back(AW'(m_fp));
               exp_data_q.push_back(bus.req_kind ? DW'(TC) : DW'(TN));
               exp_wcyc_q.push_back(cyc + 1);
               exp_addr_q.push_back(AW'(m_fp + 1));
               exp_data_q.push_back(bus.req_a);
               exp_wcyc_q.push_back(cyc + 2);
               if (bus.req_kind) begin
                  exp_addr_q.push_back(AW'(m_fp + 2));
                  exp_data_q.push_back(bus.req_b);
                  exp_wcyc_q.push_back(cyc + 3);
               end
               exp_done_q.push_back(AW'(m_fp));
               exp_dcyc_q.push_back(cyc + sz + 1);
               m_fp = m_fp + sz;
            end
         end
      end
   end

   task automatic do_req(input logic kind, input logic [DW-1:0] a, input logic [DW-1:0] b);
      int n;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_kind  = kind;
      bus.req_a     = a;
      bus.req_b     = b;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.req_ready && n < 50);
      if (!bus.req_ready) check("handshake_timeout", 0, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_done(output logic [AW-1:0] addr);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 50);
      if (!bus.done) begin
         check("done_timeout", 0, 1);
         addr = 'x;
      end else begin
         addr = bus.done_addr;
      end
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      flush_model();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   logic [AW-1:0] da;
   int            hs0;
   int            nh;
   int            k;

   initial begin
      rst            = 1'b1;
      bus.heap_clear = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_kind   = 1'b0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", bus.req_ready, 0);
      check("rst_done", bus.done, 0);
      check("rst_done_addr", bus.done_addr, 0);
      check("rst_alloc_error", bus.alloc_error, 0);
      check("rst_we", bus.mem_write_enable, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_data", bus.mem_write_data, 0);
      check("rst_free_ptr", bus.free_ptr, 'h0100);
      rst = 1'b0;
      #1 check("ready_after_rst", bus.req_ready, 1);

      // Single number
      do_req(1'b0, 'h002A, 'h0);
      wait_done(da);
      check("t1_done_addr", da, 'h0100);
      @(posedge clk); #1;
      check("t1_free_ptr", bus.free_ptr, 'h0102);
      check("t1_mem_tag", mem_model['h100], TN);
      check("t1_readback", mem_model['h101], 'h002A);

      // Cons after number
      do_req(1'b1, 'h0100, 'h0000);
      wait_done(da);
      check("t2_done_addr", da, 'h0102);
      @(posedge clk); #1;
      check("t2_free_ptr", bus.free_ptr, 'h0105);
      check("t2_mem_tag", mem_model['h102], TC);
      check("t2_mem_car", mem_model['h103], 'h0100);
      check("t2_mem_cdr", mem_model['h104], 'h0000);

      // Back-to-back numbers with req_valid held high
      apply_reset();
      done_log.delete();
      hs0 = hs_count;
      bus.req_valid = 1'b1;
      bus.req_kind  = 1'b0;
      bus.req_a     = 'h0011;
      nh = 0;
      k  = 0;
      while (nh < 3 && k < 60) begin
         @(negedge clk);
         k++;
         if (bus.req_ready) begin
            nh++;
            @(posedge clk); #1;
            bus.req_a = bus.req_a + 1;
            if (nh == 3) bus.req_valid = 1'b0;
         end
      end
      wait_done(da);
      repeat (3) @(posedge clk);
      #1;
      check("t3_handshakes", hs_count - hs0, 3);
      check("t3_done_count", done_log.size(), 3);
      if (done_log.size() == 3) begin
         check("t3_done0", done_log[0], 'h0100);
         check("t3_done1", done_log[1], 'h0102);
         check("t3_done2", done_log[2], 'h0104);
      end
      if (hs_cyc_q.size() >= 3) begin
         check("t3_gap1", hs_cyc_q[hs_cyc_q.size()-2] - hs_cyc_q[hs_cyc_q.size()-3], 4);
         check("t3_gap2", hs_cyc_q[hs_cyc_q.size()-1] - hs_cyc_q[hs_cyc_q.size()-2], 4);
      end

      // Fill to 0x01FE, exact fit, then overflow
      apply_reset();
      repeat (2) begin
         do_req(1'b1, DW'($urandom_range(0, 'hFFFF)), DW'($urandom_range(0, 'hFFFF)));
         wait_done(da);
      end
      repeat (124) begin
         do_req(1'b0, DW'($urandom_range(0, 'hFFFF)), 'h0);
         wait_done(da);
      end
      @(posedge clk); #1;
      check("t4_fill_free_ptr", bus.free_ptr, 'h01FE);
      do_req(1'b0, 'h0077, 'h0);
      wait_done(da);
      check("t4_fit_addr", da, 'h01FE);
      @(posedge clk); #1;
      check("t4_fit_free_ptr", bus.free_ptr, 'h0200);
      do_req(1'b0, 'h0088, 'h0);
      check("t4_err_rise", bus.alloc_error, 1);
      check("t4_err_ready", bus.req_ready, 0);
      check("t4_err_we", bus.mem_write_enable, 0);
      repeat (3) @(posedge clk);
      #1;
      check("t4_err_sticky", bus.alloc_error, 1);
      check("t4_err_free_ptr", bus.free_ptr, 'h0200);
      bus.heap_clear = 1'b1;
      @(posedge clk); #1;
      bus.heap_clear = 1'b0;
      check("t4_clr_err", bus.alloc_error, 0);
      check("t4_clr_free_ptr", bus.free_ptr, 'h0100);
      #1 check("t4_clr_ready", bus.req_ready, 1);

      // Clear and request in the same IDLE cycle
      do_req(1'b0, 'h0005, 'h0);
      wait_done(da);
      check("t5_first_addr", da, 'h0100);
      @(posedge clk); #1;
      bus.heap_clear = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_kind   = 1'b0;
      bus.req_a      = 'h0055;
      #1 check("t5_collide_ready", bus.req_ready, 0);
      @(posedge clk); #1;
      bus.heap_clear = 1'b0;
      check("t5_cleared_free_ptr", bus.free_ptr, 'h0100);
      @(negedge clk);
      check("t5_next_ready", bus.req_ready, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      wait_done(da);
      check("t5_collide_addr", da, 'h0100);

      // Asynchronous reset during the third word of a cons
      do_req(1'b1, 'h0100, 'h0102);
      @(posedge clk);
      @(posedge clk);
      #3;
      check("t6_w2_we", bus.mem_write_enable, 1);
      check("t6_w2_addr", bus.mem_addr, 'h0104);
      rst = 1'b1;
      flush_model();
      #1;
      check("t6_rst_we", bus.mem_write_enable, 0);
      check("t6_rst_done", bus.done, 0);
      check("t6_rst_err", bus.alloc_error, 0);
      check("t6_rst_free_ptr", bus.free_ptr, 'h0100);
      check("t6_rst_ready", bus.req_ready, 0);
      repeat (2) @(posedge clk);
      #2 check("t6_rst_ready_held", bus.req_ready, 0);
      rst = 1'b0;
      #1 check("t6_ready_release", bus.req_ready, 1);
      do_req(1'b0, 'h0099, 'h0);
      wait_done(da);
      check("t6_after_addr", da, 'h0100);

      repeat (3) @(posedge clk);
      #1;
      check("end_pending_writes", exp_addr_q.size(), 0);
      check("end_pending_dones", exp_done_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1);
   end

endmodule
